// File: rtl/jp_pkg.sv
// Shared constants and types for the joypad responder.
package jp_pkg;

  // Button bit positions within a pad byte (1 = pressed in the register).
  localparam int JP_A      = 0;
  localparam int JP_B      = 1;
  localparam int JP_SELECT = 2;
  localparam int JP_START  = 3;
  localparam int JP_UP     = 4;
  localparam int JP_DOWN   = 5;
  localparam int JP_LEFT   = 6;
  localparam int JP_RIGHT  = 7;

  // Bus register select values.
  localparam logic JP_ADR_BUTTONS = 1'b0;
  localparam logic JP_ADR_STATUS  = 1'b1;

  // Bits shifted out per latch, and the index value that ends a readout.
  localparam int         JP_NUM_BITS = 8;
  localparam logic [3:0] JP_IDX_DONE = 4'(JP_NUM_BITS);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } jp_state_e;

endpackage

// File: rtl/jp_sync_filt.sv
// Synchronizer, consecutive-sample level filter and edge pulses for one
// asynchronous strobe. The filter timer is a down-counter that reloads
// whenever the sample agrees with the current level; reaching zero on a
// disagreeing sample flips the level.
module jp_sync_filt #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk_in,
  input  logic nrst_in,
  input  logic async_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  // Next-state: shift the synchronizer, run the filter timer, flag edges.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], async_in};
    level_d = level_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sample == level_q) begin
      cnt_d = CNT_RELOAD;
    end else if (cnt_q == '0) begin
      level_d = sample;
      cnt_d   = CNT_RELOAD;
      rise_d  = sample;
      fall_d  = ~sample;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!nrst_in) begin
      sync_q  <= '0;
      cnt_q   <= CNT_RELOAD;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;

endmodule

// File: rtl/jp_responder.sv
// Two-pad NES controller emulator driven by the console latch/clk strobes,
// with button state and a latch counter on a simple IO bus.
//
//   state | meaning
//   LOAD  | latch high: shift registers track the button register, index 0
//   SHIFT | latch released: each clk rise shifts one bit out, fills with 1
//   DONE  | eight bits sent: hold registers, index stays at 8
module jp_responder
  import jp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic        clk_in,
  input  logic        nrst_in,
  input  logic        jp_latch_in,
  input  logic        jp_clk_in,
  output logic        jp_data1_out,
  output logic        jp_data2_out,
  input  logic [31:0] Bus2IP_Data,
  input  logic        Bus2IP_Adr,
  input  logic        Bus2IP_RD,
  input  logic        Bus2IP_WR,
  input  logic        Bus2IP_CS,
  output logic [31:0] IP2Bus_Data,
  output logic        IP2Bus_RdAck,
  output logic        IP2Bus_WrAck
);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_lvl, clk_rise, clk_fall;
  logic wr_stb, rd_stb;
  logic unused_ok;

  jp_state_e   state_q, state_d;
  logic [7:0]  shift1_q, shift1_d, shift2_q, shift2_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] btn_q, btn_d;
  logic [15:0] latch_cnt_q, latch_cnt_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;

  jp_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_latch_filt (
    .clk_in(clk_in), .nrst_in(nrst_in), .async_in(jp_latch_in),
    .level_out(latch_lvl), .rise_out(latch_rise), .fall_out(latch_fall)
  );

  jp_sync_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_clk_filt (
    .clk_in(clk_in), .nrst_in(nrst_in), .async_in(jp_clk_in),
    .level_out(clk_lvl), .rise_out(clk_rise), .fall_out(clk_fall)
  );

  assign unused_ok = ^{clk_lvl, clk_fall, Bus2IP_Data[31:16]};
  assign wr_stb    = Bus2IP_CS & Bus2IP_WR;
  assign rd_stb    = Bus2IP_CS & Bus2IP_RD;

  // Shift FSM: a high latch always wins and keeps reloading from the buttons.
  always_comb begin
    state_d  = state_q;
    shift1_d = shift1_q;
    shift2_d = shift2_q;
    idx_d    = idx_q;
    if (latch_lvl) begin
      state_d  = LOAD;
      shift1_d = btn_q[7:0];
      shift2_d = btn_q[15:8];
      idx_d    = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (latch_fall) state_d = SHIFT;
        end
        SHIFT: begin
          if (clk_rise) begin
            shift1_d = {1'b1, shift1_q[7:1]};
            shift2_d = {1'b1, shift2_q[7:1]};
            idx_d    = idx_q + 4'd1;
            if (idx_d == JP_IDX_DONE) state_d = DONE;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = DONE;
      endcase
    end
  end

  // Bus side: button writes, saturating latch counter with clear priority, acks.
  always_comb begin
    btn_d       = btn_q;
    latch_cnt_d = latch_cnt_q;
    wr_ack_d    = wr_stb;
    rd_ack_d    = rd_stb;
    rd_data_d   = '0;
    if (wr_stb && Bus2IP_Adr == JP_ADR_BUTTONS) btn_d = Bus2IP_Data[15:0];
    if (latch_rise && latch_cnt_q != 16'hFFFF) latch_cnt_d = latch_cnt_q + 16'd1;
    if (wr_stb && Bus2IP_Adr == JP_ADR_STATUS) latch_cnt_d = '0;
    if (rd_stb) begin
      if (Bus2IP_Adr == JP_ADR_BUTTONS) rd_data_d = {16'd0, btn_q};
      else                              rd_data_d = {12'd0, idx_q, latch_cnt_q};
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!nrst_in) begin
      state_q     <= DONE;
      shift1_q    <= '0;
      shift2_q    <= '0;
      idx_q       <= '0;
      btn_q       <= '0;
      latch_cnt_q <= '0;
      rd_data_q   <= '0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift1_q    <= shift1_d;
      shift2_q    <= shift2_d;
      idx_q       <= idx_d;
      btn_q       <= btn_d;
      latch_cnt_q <= latch_cnt_d;
      rd_data_q   <= rd_data_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
    end
  end

  assign jp_data1_out = ~shift1_q[0];
  assign jp_data2_out = ~shift2_q[0];
  assign IP2Bus_Data  = rd_data_q;
  assign IP2Bus_RdAck = rd_ack_q;
  assign IP2Bus_WrAck = wr_ack_q;

endmodule

// File: tb/tb_jp_responder.sv
// Self-checking bench for jp_responder at default parameters.
module tb_jp_responder;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        jp_latch = 1'b0;
  logic        jp_clk = 1'b0;
  logic        jp_data1, jp_data2;
  logic [31:0] bus_wdata = '0;
  logic        bus_adr = 1'b0;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic        bus_cs = 1'b0;
  logic [31:0] bus_rdata;
  logic        rd_ack, wr_ack;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb_q[$];

  jp_responder dut (
    .clk_in(clk), .nrst_in(nrst), .jp_latch_in(jp_latch), .jp_clk_in(jp_clk),
    .jp_data1_out(jp_data1), .jp_data2_out(jp_data2),
    .Bus2IP_Data(bus_wdata), .Bus2IP_Adr(bus_adr), .Bus2IP_RD(bus_rd),
    .Bus2IP_WR(bus_wr), .Bus2IP_CS(bus_cs), .IP2Bus_Data(bus_rdata),
    .IP2Bus_RdAck(rd_ack), .IP2Bus_WrAck(wr_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1);
  end

  // Single write; returns number of WrAck cycles seen in a 3-cycle window.
  task automatic bus_write(input logic adr, input logic [31:0] data, output int acks);
    @(negedge clk);
    bus_adr = adr; bus_wdata = data; bus_cs = 1'b1; bus_wr = 1'b1;
    @(negedge clk);
    bus_cs = 1'b0; bus_wr = 1'b0;
    acks = 0;
    repeat (3) begin
      if (wr_ack) acks++;
      @(negedge clk);
    end
  endtask

  // Single read; data captured during RdAck, leak counts nonzero data outside it.
  task automatic bus_read(input logic adr, output logic [31:0] data, output int acks,
                          output int leak);
    @(negedge clk);
    bus_adr = adr; bus_cs = 1'b1; bus_rd = 1'b1;
    @(negedge clk);
    bus_cs = 1'b0; bus_rd = 1'b0;
    acks = 0; leak = 0; data = '0;
    repeat (3) begin
      if (rd_ack) begin acks++; data = bus_rdata; end
      else if (bus_rdata !== 32'd0) leak++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_latch(input int n);
    @(negedge clk); jp_latch = 1'b1;
    repeat (n) @(negedge clk);
    jp_latch = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic pulse_clk(input int n);
    @(negedge clk); jp_clk = 1'b1;
    repeat (n) @(negedge clk);
    jp_clk = 1'b0;
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d; int a, l;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({jp_data1, jp_data2} !== 2'b11) begin n_errors++;
      $display("FAIL reset_data: got %b required 11", {jp_data1, jp_data2}); end
    n_checks++; if ({rd_ack, wr_ack} !== 2'b00) begin n_errors++;
      $display("FAIL reset_acks: got %b required 00", {rd_ack, wr_ack}); end
    n_checks++; if (bus_rdata !== 32'd0) begin n_errors++;
      $display("FAIL reset_rdata: got %h required 0", bus_rdata); end
    nrst = 1'b1;
    @(negedge clk);
    sb_q.push_back(32'd0); sb_q.push_back(32'd0);
    bus_read(1'b0, d, a, l);
    n_checks++; if (d !== sb_q.pop_front() || a !== 1) begin n_errors++;
      $display("FAIL reset_buttons: got %h acks %0d required 0 acks 1", d, a); end
    bus_read(1'b1, d, a, l);
    n_checks++; if (d !== sb_q.pop_front() || a !== 1) begin n_errors++;
      $display("FAIL reset_status: got %h acks %0d required 0 acks 1", d, a); end
  endtask

  task automatic test_readout();
    logic [7:0] p1, p2; logic [31:0] d, e; int a, l;
    p1 = 8'h01; p2 = 8'hA5;
    bus_write(1'b0, 32'h0000_A501, a);
    n_checks++; if (a !== 1) begin n_errors++;
      $display("FAIL readout_wrack: got %0d ack cycles required 1", a); end
    for (int i = 0; i < 8; i++) sb_q.push_back({30'd0, ~p1[i], ~p2[i]});
    sb_q.push_back(32'd0);
    pulse_latch(12);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) pulse_clk(20);
      e = sb_q.pop_front();
      n_checks++; if ({jp_data1, jp_data2} !== e[1:0]) begin n_errors++;
        $display("FAIL readout_bit%0d: got %b required %b", i, {jp_data1, jp_data2}, e[1:0]); end
    end
    bus_read(1'b1, d, a, l);
    n_checks++; if (d !== 32'h0008_0001 || l !== 0) begin n_errors++;
      $display("FAIL readout_status: got %h leak %0d required 00080001 leak 0", d, l); end
  endtask

  task automatic test_latency_and_load_write();
    int a;
    bus_write(1'b0, 32'h0000_0302, a);
    @(negedge clk); jp_latch = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++; if ({jp_data1, jp_data2} !== 2'b00) begin n_errors++;
      $display("FAIL latency_early: got %b required 00", {jp_data1, jp_data2}); end
    @(negedge clk);
    n_checks++; if ({jp_data1, jp_data2} !== 2'b10) begin n_errors++;
      $display("FAIL latency_7: got %b required 10", {jp_data1, jp_data2}); end
    bus_adr = 1'b0; bus_wdata = 32'h0000_0001; bus_cs = 1'b1; bus_wr = 1'b1;
    @(negedge clk);
    bus_cs = 1'b0; bus_wr = 1'b0;
    n_checks++; if ({jp_data1, jp_data2} !== 2'b10) begin n_errors++;
      $display("FAIL load_write_early: got %b required 10", {jp_data1, jp_data2}); end
    @(negedge clk);
    n_checks++; if ({jp_data1, jp_data2} !== 2'b01) begin n_errors++;
      $display("FAIL load_write: got %b required 01", {jp_data1, jp_data2}); end
  endtask

  task automatic test_clk_during_latch();
    logic [31:0] d; int a, l;
    pulse_clk(20);
    pulse_clk(20);
    n_checks++; if ({jp_data1, jp_data2} !== 2'b01) begin n_errors++;
      $display("FAIL clk_in_latch_data: got %b required 01", {jp_data1, jp_data2}); end
    bus_read(1'b1, d, a, l);
    n_checks++; if (d !== 32'h0000_0002) begin n_errors++;
      $display("FAIL clk_in_latch_status: got %h required 00000002", d); end
    jp_latch = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch();
    logic [31:0] d; int a, l;
    pulse_clk(3);
    bus_read(1'b1, d, a, l);
    n_checks++; if (d !== 32'h0000_0002) begin n_errors++;
      $display("FAIL glitch_3cyc: got %h required 00000002", d); end
    pulse_clk(4);
    bus_read(1'b1, d, a, l);
    n_checks++; if (d !== 32'h0001_0002) begin n_errors++;
      $display("FAIL glitch_4cyc: got %h required 00010002", d); end
    n_checks++; if ({jp_data1, jp_data2} !== 2'b11) begin n_errors++;
      $display("FAIL glitch_data: got %b required 11", {jp_data1, jp_data2}); end
  endtask

  task automatic test_write_mid_shift();
    logic [7:0] p1, p2; logic [31:0] d, e; int a, l;
    p1 = 8'h5A; p2 = 8'hC3;
    bus_write(1'b0, 32'h0000_C35A, a);
    for (int i = 0; i < 8; i++) sb_q.push_back({30'd0, ~p1[i], ~p2[i]});
    sb_q.push_back(32'd0);
    pulse_latch(12);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) pulse_clk(20);
      if (i == 3) bus_write(1'b0, 32'h0000_00FF, a);
      e = sb_q.pop_front();
      n_checks++; if ({jp_data1, jp_data2} !== e[1:0]) begin n_errors++;
        $display("FAIL midshift_bit%0d: got %b required %b", i, {jp_data1, jp_data2}, e[1:0]); end
    end
    bus_read(1'b0, d, a, l);
    n_checks++; if (d !== 32'h0000_00FF) begin n_errors++;
      $display("FAIL midshift_readback: got %h required 000000ff", d); end
    pulse_latch(12);
    n_checks++; if ({jp_data1, jp_data2} !== 2'b01) begin n_errors++;
      $display("FAIL midshift_reload0: got %b required 01", {jp_data1, jp_data2}); end
    pulse_clk(20);
    n_checks++; if ({jp_data1, jp_data2} !== 2'b01) begin n_errors++;
      $display("FAIL midshift_reload1: got %b required 01", {jp_data1, jp_data2}); end
  endtask

  task automatic test_counter();
    logic [31:0] d; int a, l;
    bus_write(1'b1, 32'hDEAD_BEEF, a);
    n_checks++; if (a !== 1) begin n_errors++;
      $display("FAIL counter_clear_wrack: got %0d ack cycles required 1", a); end
    bus_read(1'b1, d, a, l);
    n_checks++; if (d !== 32'h0001_0000) begin n_errors++;
      $display("FAIL counter_cleared: got %h required 00010000", d); end
    repeat (3) pulse_latch(12);
    bus_read(1'b1, d, a, l);
    n_checks++; if (d !== 32'h0000_0003 || a !== 1 || l !== 0) begin n_errors++;
      $display("FAIL counter_three: got %h acks %0d leak %0d required 00000003 acks 1 leak 0",
               d, a, l); end
    // Clear lands on the same edge that consumes the latch rise pulse.
    @(negedge clk); jp_latch = 1'b1;
    repeat (6) @(negedge clk);
    bus_adr = 1'b1; bus_wdata = 32'd0; bus_cs = 1'b1; bus_wr = 1'b1;
    @(negedge clk);
    bus_cs = 1'b0; bus_wr = 1'b0;
    repeat (6) @(negedge clk);
    jp_latch = 1'b0;
    repeat (10) @(negedge clk);
    bus_read(1'b1, d, a, l);
    n_checks++; if (d !== 32'h0000_0000) begin n_errors++;
      $display("FAIL counter_clear_wins: got %h required 00000000", d); end
    @(negedge clk);
    force dut.latch_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.latch_cnt_q;
    pulse_latch(12);
    bus_read(1'b1, d, a, l);
    n_checks++; if (d !== 32'h0000_FFFF) begin n_errors++;
      $display("FAIL counter_saturate: got %h required 0000ffff", d); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seen; logic [31:0] e;
    @(negedge clk);
    bus_adr = 1'b0; bus_wdata = 32'h0000_1111; bus_cs = 1'b1; bus_wr = 1'b1;
    @(negedge clk); seen[2] = wr_ack;
    bus_wdata = 32'h0000_2222;
    @(negedge clk); seen[1] = wr_ack;
    bus_cs = 1'b0; bus_wr = 1'b0;
    @(negedge clk); seen[0] = wr_ack;
    n_checks++; if (seen !== 3'b110) begin n_errors++;
      $display("FAIL b2b_wrack: got %b required 110", seen); end
    sb_q.push_back(32'h0000_2222);
    sb_q.push_back(32'h0000_FFFF);
    @(negedge clk);
    bus_adr = 1'b0; bus_cs = 1'b1; bus_rd = 1'b1;
    @(negedge clk);
    bus_adr = 1'b1;
    e = sb_q.pop_front();
    n_checks++; if (rd_ack !== 1'b1 || bus_rdata !== e) begin n_errors++;
      $display("FAIL b2b_read0: got ack %b data %h required ack 1 data %h", rd_ack, bus_rdata, e); end
    @(negedge clk);
    bus_cs = 1'b0; bus_rd = 1'b0;
    e = sb_q.pop_front();
    n_checks++; if (rd_ack !== 1'b1 || bus_rdata !== e) begin n_errors++;
      $display("FAIL b2b_read1: got ack %b data %h required ack 1 data %h", rd_ack, bus_rdata, e); end
    @(negedge clk);
    n_checks++; if (rd_ack !== 1'b0 || bus_rdata !== 32'd0) begin n_errors++;
      $display("FAIL b2b_idle: got ack %b data %h required ack 0 data 0", rd_ack, bus_rdata); end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] d; int a, l;
    bus_write(1'b0, 32'h0000_0010, a);
    pulse_latch(12);
    repeat (4) pulse_clk(20);
    n_checks++; if ({jp_data1, jp_data2} !== 2'b01) begin n_errors++;
      $display("FAIL rst_mid_pre: got %b required 01", {jp_data1, jp_data2}); end
    nrst = 1'b0;
    @(negedge clk);
    n_checks++; if ({jp_data1, jp_data2} !== 2'b11) begin n_errors++;
      $display("FAIL rst_mid_data: got %b required 11", {jp_data1, jp_data2}); end
    nrst = 1'b1;
    bus_read(1'b1, d, a, l);
    n_checks++; if (d !== 32'd0 || a !== 1) begin n_errors++;
      $display("FAIL rst_mid_status: got %h acks %0d required 0 acks 1", d, a); end
    bus_read(1'b0, d, a, l);
    n_checks++; if (d !== 32'd0) begin n_errors++;
      $display("FAIL rst_mid_buttons: got %h required 0", d); end
  endtask

  initial begin
    test_reset();
    test_readout();
    test_latency_and_load_write();
    test_clk_during_latch();
    test_glitch();
    test_write_mid_shift();
    test_counter();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
